hidden_ram_pipe: RTL and testbench

Parametrised, byte-writable register-file RAM with a registered read port, write-first bypass, out-of-range address protection and a sequential scrub (clear) engine. It replaces the fixed 16x128 combinational-read scratch RAM in the frame-data path: writers deposit pixel or palette words, readers fetch them one cycle later, and firmware can wipe the array at run time without a reset.

---
 rtl/hidden_ram_pipe_pkg.sv | 30 +++
 rtl/hidden_ram_pipe_if.sv | 32 +++
 rtl/hidden_ram_pipe_scrub.sv | 71 +++++++
 rtl/hidden_ram_pipe.sv | 134 +++++++++++++
 tb/tb_hidden_ram_pipe.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hidden_ram_pipe_pkg.sv
// Shared types and helpers for the hidden_ram_pipe scratch RAM.
package hidden_ram_pkg;

    // Scrub engine state: IDLE accepts user traffic, SCRUB zeroes one word per cycle.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } scrub_state_e;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Byte-enable merge: bytes with be[b] set come from new_word, the rest keep old_word.
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_BE_W; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/hidden_ram_pipe_if.sv
// Request/response bundle for hidden_ram_pipe; clock and reset stay outside.
interface hidden_ram_pipe_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;

    logic              i_write;
    logic [ADDR_W-1:0] i_addr_w;
    logic [DATA_W-1:0] i_wdata;
    logic [BE_W-1:0]   i_wbe;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr_r;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rvalid;
    logic              i_clear;
    logic              o_busy;
    logic              o_drop;
    logic              o_oor;

    modport master (
        output i_write, i_addr_w, i_wdata, i_wbe, i_read, i_addr_r, i_clear,
        input  o_rdata, o_rvalid, o_busy, o_drop, o_oor
    );

    modport slave (
        input  i_write, i_addr_w, i_wdata, i_wbe, i_read, i_addr_r, i_clear,
        output o_rdata, o_rvalid, o_busy, o_drop, o_oor
    );

endinterface

// File: rtl/hidden_ram_pipe_scrub.sv
// Scrub engine: walks the array from word 0 to DEPTH-1, one zero-write per cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | user reads/writes accepted; i_clear starts a scrub at word 0
// SCRUB | word[ptr] zeroed every cycle; returns to IDLE after DEPTH-1
module hidden_ram_scrub
    import hidden_ram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_zero_we,
    output logic [ADDR_W-1:0] o_zero_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              zero_we;

    // State and pointer registers; reset aborts any scrub in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic and the per-cycle zero-write strobe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        zero_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_clear) begin
                    state_d = SCRUB;
                    ptr_d   = '0;
                end
            end
            SCRUB: begin
                zero_we = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Busy is a decode of the state flop, so it stays glitch-free and registered.
    assign o_busy      = (state_q == SCRUB);
    assign o_zero_we   = zero_we;
    assign o_zero_addr = ptr_q;

endmodule

// File: rtl/hidden_ram_pipe.sv
// Byte-writable flop RAM with registered read, write-first bypass,
// out-of-range protection and a run-time scrub engine.
module hidden_ram_pipe
    import hidden_ram_pkg::*;
#(
    parameter int DATA_W = 128,   // multiple of 8, at most MAX_DATA_W
    parameter int DEPTH  = 16     // any value >= 2
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    hidden_ram_pipe_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              drop_q, drop_d;
    logic              oor_q, oor_d;

    logic              busy;
    logic              zero_we;
    logic [ADDR_W-1:0] zero_addr;

    logic              wr_in, rd_in;
    logic              wr_acc, rd_acc;
    logic              user_we;
    logic              bypass;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    hidden_ram_scrub #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scrub (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clear     (bus.i_clear),
        .o_busy      (busy),
        .o_zero_we   (zero_we),
        .o_zero_addr (zero_addr)
    );

    // Request qualification: range checks, acceptance and the merged write word.
    always_comb begin
        wr_in    = ({1'b0, bus.i_addr_w} < DEPTH_L);
        rd_in    = ({1'b0, bus.i_addr_r} < DEPTH_L);
        // A clear in IDLE wins over a same-cycle write, but not over a read.
        wr_acc   = bus.i_write & ~busy & ~bus.i_clear;
        rd_acc   = bus.i_read & ~busy;
        user_we  = wr_acc & wr_in;
        bypass   = user_we & rd_in & (bus.i_addr_w == bus.i_addr_r);
        old_word = '0;
        rd_word  = '0;
        // Loop lookups keep out-of-range addresses from ever indexing the array.
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.i_addr_w == ADDR_W'(i)) begin
                old_word = mem_q[i];
            end
            if (bus.i_addr_r == ADDR_W'(i)) begin
                rd_word = mem_q[i];
            end
        end
        merged = DATA_W'(be_merge(MAX_DATA_W'(old_word),
                                  MAX_DATA_W'(bus.i_wdata),
                                  MAX_BE_W'(bus.i_wbe)));
    end

    // Array next-state: scrub zero-write or user write (never both, user needs IDLE).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (zero_we && (zero_addr == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end else if (user_we && (bus.i_addr_w == ADDR_W'(i))) begin
                mem_d[i] = merged;
            end
        end
    end

    // Registered response and status pulses.
    always_comb begin
        rdata_d  = '0;
        rvalid_d = rd_acc;
        if (rd_acc && rd_in) begin
            rdata_d = bypass ? merged : rd_word;
        end
        drop_d = (busy & (bus.i_write | bus.i_read)) |
                 (~busy & bus.i_clear & bus.i_write);
        // One pulse even when both ports are out of range together.
        oor_d  = (wr_acc & ~wr_in) | (rd_acc & ~rd_in);
    end

    // Register file storage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            drop_q   <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            drop_q   <= drop_d;
            oor_q    <= oor_d;
        end
    end

    assign bus.o_rdata  = rdata_q;
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_busy   = busy;
    assign bus.o_drop   = drop_q;
    assign bus.o_oor    = oor_q;

endmodule

// File: tb/tb_hidden_ram_pipe.sv
// Directed bench for hidden_ram_pipe: a 16-word and a 12-word instance.
module tb_hidden_ram_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hidden_ram_pipe_if #(.DATA_W(128), .DEPTH(16)) bus16 ();
    hidden_ram_pipe_if #(.DATA_W(128), .DEPTH(12)) bus12 ();

    hidden_ram_pipe #(.DATA_W(128), .DEPTH(16)) u_dut16 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus16)
    );

    hidden_ram_pipe #(.DATA_W(128), .DEPTH(12)) u_dut12 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus12)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        bus16.i_write  = 1'b0;
        bus16.i_addr_w = '0;
        bus16.i_wdata  = '0;
        bus16.i_wbe    = '0;
        bus16.i_read   = 1'b0;
        bus16.i_addr_r = '0;
        bus16.i_clear  = 1'b0;
    endtask

    task automatic idle12();
        bus12.i_write  = 1'b0;
        bus12.i_addr_w = '0;
        bus12.i_wdata  = '0;
        bus12.i_wbe    = '0;
        bus12.i_read   = 1'b0;
        bus12.i_addr_r = '0;
        bus12.i_clear  = 1'b0;
    endtask

    task automatic wr16(input int a, input logic [127:0] d, input logic [15:0] be);
        bus16.i_write  = 1'b1;
        bus16.i_addr_w = 4'(a);
        bus16.i_wdata  = d;
        bus16.i_wbe    = be;
    endtask

    task automatic rd16(input int a);
        bus16.i_read   = 1'b1;
        bus16.i_addr_r = 4'(a);
    endtask

    initial begin
        logic [7:0]   bv;
        int           busy_cnt;
        int           drop_cnt;
        int           rv_cnt;

        idle16();
        idle12();

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_rdata",  bus16.o_rdata,  128'h0);
        check("rst_rvalid", bus16.o_rvalid, 1'b0);
        check("rst_busy",   bus16.o_busy,   1'b0);
        check("rst_drop",   bus16.o_drop,   1'b0);
        check("rst_oor",    bus16.o_oor,    1'b0);
        rst_n = 1'b1;
        tick();

        // Back-to-back reads of all default words
        for (int i = 0; i < 16; i++) begin
            idle16();
            rd16(i);
            tick();
            check($sformatf("dflt_rvalid%0d", i), bus16.o_rvalid, 1'b1);
            check($sformatf("dflt_rdata%0d", i),  bus16.o_rdata,  128'h0);
            check($sformatf("dflt_flags%0d", i),
                  {bus16.o_busy, bus16.o_drop, bus16.o_oor}, 3'b000);
        end
        idle16();
        tick();
        check("rd_end_rvalid", bus16.o_rvalid, 1'b0);

        // Byte-enable merge on word 5
        wr16(5, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF);
        tick();
        check("wr_no_rvalid", bus16.o_rvalid, 1'b0);
        wr16(5, {128{1'b1}}, 16'h0001);
        tick();
        idle16();
        rd16(5);
        tick();
        check("be0_rvalid", bus16.o_rvalid, 1'b1);
        check("be0_rdata",  bus16.o_rdata, 128'h00112233445566778899AABBCCDDEEFF);
        idle16();
        wr16(5, {128{1'b1}}, 16'h8002);
        tick();
        idle16();
        wr16(5, 128'h0, 16'h0000);
        rd16(5);
        tick();
        check("be_8002_rdata", bus16.o_rdata, 128'hFF112233445566778899AABBCCDDFFFF);

        // Write-first bypass on word 3, old value on word 4
        idle16();
        wr16(3, {16{8'hA5}}, 16'hFFFF);
        rd16(3);
        tick();
        check("byp_rvalid", bus16.o_rvalid, 1'b1);
        check("byp_rdata",  bus16.o_rdata, {16{8'hA5}});
        idle16();
        wr16(3, {16{8'h5A}}, 16'hFFFF);
        rd16(4);
        tick();
        check("byp_other_rdata", bus16.o_rdata, 128'h0);
        idle16();
        wr16(3, 128'h0, 16'h00F0);
        rd16(3);
        tick();
        check("byp_partial_rdata", bus16.o_rdata, 128'h5A5A5A5A_5A5A5A5A_00000000_5A5A5A5A);

        // Fill all words, then scrub with rejected traffic mid-way
        for (int i = 0; i < 16; i++) begin
            idle16();
            bv = 8'(i + 1);
            wr16(i, {16{bv}}, 16'hFFFF);
            tick();
        end
        idle16();
        rd16(9);
        tick();
        check("fill_rdata9", bus16.o_rdata, {16{8'h0A}});

        idle16();
        bus16.i_clear = 1'b1;
        rd16(9);
        tick();
        check("clr_rd_rvalid", bus16.o_rvalid, 1'b1);
        check("clr_rd_rdata",  bus16.o_rdata,  {16{8'h0A}});
        busy_cnt = int'(bus16.o_busy);
        drop_cnt = 0;
        rv_cnt   = 0;
        for (int c = 0; c < 20; c++) begin
            idle16();
            if (c == 6) wr16(0, {128{1'b1}}, 16'hFFFF);
            if (c == 7) rd16(0);
            if (c == 9) bus16.i_clear = 1'b1;
            tick();
            busy_cnt += int'(bus16.o_busy);
            drop_cnt += int'(bus16.o_drop);
            rv_cnt   += int'(bus16.o_rvalid);
        end
        check("scrub_busy_cycles", 128'(busy_cnt), 128'd16);
        check("scrub_drop_pulses", 128'(drop_cnt), 128'd2);
        check("scrub_rvalid",      128'(rv_cnt),   128'd0);
        for (int i = 0; i < 16; i++) begin
            idle16();
            rd16(i);
            tick();
            check($sformatf("post_scrub_rdata%0d", i), bus16.o_rdata, 128'h0);
        end

        // Clear with same-cycle write: write dropped, scrub starts
        idle16();
        wr16(7, {16{8'h33}}, 16'hFFFF);
        bus16.i_clear = 1'b1;
        tick();
        check("clr_wr_drop", bus16.o_drop, 1'b1);
        check("clr_wr_busy", bus16.o_busy, 1'b1);
        idle16();
        for (int c = 0; c < 17; c++) tick();
        rd16(7);
        tick();
        check("clr_wr_rdata7", bus16.o_rdata, 128'h0);
        idle16();

        // DEPTH=12 instance: out-of-range accesses
        bus12.i_write  = 1'b1;
        bus12.i_addr_w = 4'd1;
        bus12.i_wdata  = {16{8'h11}};
        bus12.i_wbe    = 16'hFFFF;
        tick();
        bus12.i_addr_w = 4'd13;
        bus12.i_wdata  = {128{1'b1}};
        bus12.i_read   = 1'b1;
        bus12.i_addr_r = 4'd14;
        tick();
        check("oor_pulse",  bus12.o_oor,    1'b1);
        check("oor_rvalid", bus12.o_rvalid, 1'b1);
        check("oor_rdata",  bus12.o_rdata,  128'h0);
        idle12();
        tick();
        check("oor_single", bus12.o_oor, 1'b0);
        bus12.i_read   = 1'b1;
        bus12.i_addr_r = 4'd1;
        tick();
        check("oor_word1",     bus12.o_rdata, {16{8'h11}});
        check("oor_inrange",   bus12.o_oor,   1'b0);
        bus12.i_addr_r = 4'd12;
        tick();
        check("oor_rd12_pulse", bus12.o_oor,   1'b1);
        check("oor_rd12_rdata", bus12.o_rdata, 128'h0);
        idle12();
        tick();

        // Reset in the middle of a scrub
        wr16(10, {16{8'h77}}, 16'hFFFF);
        tick();
        idle16();
        bus16.i_clear = 1'b1;
        tick();
        idle16();
        tick();
        tick();
        tick();
        check("mid_busy", bus16.o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_abort_busy", bus16.o_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_abort_idle", bus16.o_busy, 1'b0);
        rd16(10);
        tick();
        check("rst_word10", bus16.o_rdata, 128'h0);

        // Fresh scrub after the aborted one covers the whole array
        idle16();
        wr16(0, {16{8'hC3}}, 16'hFFFF);
        tick();
        wr16(15, {16{8'h3C}}, 16'hFFFF);
        tick();
        idle16();
        rd16(0);
        tick();
        check("restart_pre0", bus16.o_rdata, {16{8'hC3}});
        idle16();
        bus16.i_clear = 1'b1;
        tick();
        idle16();
        busy_cnt = int'(bus16.o_busy);
        for (int c = 0; c < 20; c++) begin
            tick();
            busy_cnt += int'(bus16.o_busy);
        end
        check("restart_busy_cycles", 128'(busy_cnt), 128'd16);
        rd16(0);
        tick();
        check("restart_word0", bus16.o_rdata, 128'h0);
        rd16(15);
        tick();
        check("restart_word15", bus16.o_rdata, 128'h0);
        idle16();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
